// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolver
// Description : Resolution-side partner of the 2-bit BEQ predictor. Queues
//               IF-stage predictions in order, checks each one against the
//               actual outcome in EX/MEM, and raises a one-cycle flush plus
//               PC redirect on a mispredict. Also drives predictor training
//               strobes and saturating branch/mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_beq,
  input  logic             take_status,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             stall,
  input  logic             ex_mem_if_beq,
  input  logic             taken,
  input  logic [PC_W-1:0]  ex_mem_target,
  output logic             flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             train_valid,
  output logic             train_taken,
  output logic             q_empty,
  output logic             q_full,
  output logic             err_underflow,
  output logic             err_overflow,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      c_depth   = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [PC_W-1:0]  c_pc_step = PC_W'(4);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t r_state;

  // Prediction queue: each entry is {predicted taken, fallthrough PC}
  logic            r_q_pred [DEPTH];
  logic [PC_W-1:0] r_q_pc   [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic             r_flush;
  logic             r_redirect_valid;
  logic [PC_W-1:0]  r_redirect_pc;
  logic             r_train_valid;
  logic             r_train_taken;
  logic             r_err_underflow;
  logic             r_err_overflow;
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  logic            w_empty;
  logic            w_full;
  logic            w_head_pred;
  logic [PC_W-1:0] w_head_fall;
  logic            w_resolve;
  logic            w_pop;
  logic            w_mispredict;
  logic            w_push;
  logic            w_push_ok;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_depth);
  assign w_head_pred = r_q_pred[r_rd_ptr];
  assign w_head_fall = r_q_pc[r_rd_ptr];

  // A resolution arriving during the recovery cycle belongs to the wrong path
  assign w_resolve    = ex_mem_if_beq & ~r_flush;
  assign w_pop        = w_resolve & ~w_empty;
  assign w_mispredict = w_pop & (w_head_pred != taken);
  assign w_push       = if_beq & ~stall & ~r_flush & ~w_mispredict;
  // A push into a full queue only succeeds if the head leaves this same cycle
  assign w_push_ok    = w_push & (~w_full | w_pop);

  // Queue payload storage; contents are only meaningful below r_count
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_q_pred[r_wr_ptr] <= take_status;
      r_q_pc[r_wr_ptr]   <= if_pc + c_pc_step;
    end
  end

  // Queue pointers and occupancy; a mispredict discards every younger entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_mispredict) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Recovery FSM with registered flush/redirect outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= RUN;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mispredict) begin
            r_state          <= RECOVER;
            r_flush          <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= taken ? ex_mem_target : w_head_fall;
          end
        end
        RECOVER: begin
          r_state          <= RUN;
          r_flush          <= 1'b0;
          r_redirect_valid <= 1'b0;
        end
        default: begin
          r_state          <= RUN;
          r_flush          <= 1'b0;
          r_redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  // Training strobes, sticky error flags and saturating statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_train_valid      <= 1'b0;
      r_train_taken      <= 1'b0;
      r_err_underflow    <= 1'b0;
      r_err_overflow     <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_train_valid <= ex_mem_if_beq;
      r_train_taken <= taken;
      if (w_resolve & w_empty)             r_err_underflow <= 1'b1;
      if (w_push & w_full & ~w_pop)        r_err_overflow  <= 1'b1;
      if (w_pop && r_branch_count != c_cnt_max)
        r_branch_count <= r_branch_count + 1'b1;
      if (w_mispredict && r_mispredict_count != c_cnt_max)
        r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

  assign flush            = r_flush;
  assign redirect_valid   = r_redirect_valid;
  assign redirect_pc      = r_redirect_pc;
  assign train_valid      = r_train_valid;
  assign train_taken      = r_train_taken;
  assign q_empty          = w_empty;
  assign q_full           = w_full;
  assign err_underflow    = r_err_underflow;
  assign err_overflow     = r_err_overflow;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire
